// File: rtl/dds_pkg.sv
// Shared DDS definitions: sweep FSM encoding and default datapath widths.
package dds_pkg;

  localparam int unsigned DDS_M    = 16;
  localparam int unsigned DDS_DW_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable down-counter for the per-frequency dwell; load wins over enable.
module dds_dwell_cnt #(
  parameter int unsigned DW_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [DW_W-1:0] load_val_i,
  input  logic            en_i,
  output logic            zero_o
);

  logic [DW_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DW_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving the DDS core's phase step and control inputs.
module dds_sweep_ctrl import dds_pkg::*; #(
  parameter int unsigned M    = DDS_M,
  parameter int unsigned DW_W = DDS_DW_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ic_start,
  input  logic            ic_abort,
  input  logic            ic_hold,
  input  logic            ic_mode,
  input  logic [M-1:0]    id_p_start,
  input  logic [M-1:0]    id_p_stop,
  input  logic [M-1:0]    id_p_step,
  input  logic [DW_W-1:0] id_dwell,
  output logic [M-1:0]    od_p_ac,
  output logic            oc_rst_ac,
  output logic            oc_en_ac,
  output logic            oc_val_data,
  output logic            oc_busy,
  output logic            oc_done
);

  sweep_state_t    state_q;
  logic [M-1:0]    p_start_q, p_stop_q, p_step_q, p_q;
  logic [DW_W-1:0] reload_q;
  logic            mode_q;
  logic            rst_ac_q, en_ac_q, val_q, busy_q, done_q;

  logic [DW_W-1:0] dwell_m1;
  logic [M:0]      p_next;
  logic            step_ok, dwell_end, cnt_en, cnt_load, cnt_zero;

  // A sample is consumed on every cycle val_q was high; dwell accounting follows that.
  always_comb begin
    dwell_m1  = (id_dwell == '0) ? '0 : id_dwell - DW_W'(1);
    p_next    = {1'b0, p_q} + {1'b0, p_step_q};
    step_ok   = (p_step_q != '0) && (p_next <= {1'b0, p_stop_q});
    dwell_end = (state_q == RUN) && !ic_abort && val_q && cnt_zero;
    cnt_en    = (state_q == RUN) && !ic_abort && val_q && !cnt_zero;
    cnt_load  = (state_q == LOAD) || (dwell_end && (step_ok || mode_q));
  end

  dds_dwell_cnt #(
    .DW_W (DW_W)
  ) u_dwell_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (cnt_load),
    .load_val_i (reload_q),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_start_q <= '0;
      p_stop_q  <= '0;
      p_step_q  <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      p_q       <= '0;
      rst_ac_q  <= 1'b1;
      en_ac_q   <= 1'b0;
      val_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rst_ac_q <= 1'b1;
          en_ac_q  <= 1'b0;
          val_q    <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          if (ic_start) begin
            p_start_q <= id_p_start;
            p_stop_q  <= id_p_stop;
            p_step_q  <= id_p_step;
            reload_q  <= dwell_m1;
            mode_q    <= ic_mode;
            state_q   <= LOAD;
          end
        end
        LOAD, RUN: begin
          if (ic_abort || (dwell_end && !step_ok && !mode_q)) begin
            state_q  <= DONE;
            rst_ac_q <= 1'b1;
            en_ac_q  <= 1'b0;
            val_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (state_q == LOAD) begin
            state_q  <= RUN;
            p_q      <= p_start_q;
            rst_ac_q <= 1'b1;
            en_ac_q  <= 1'b0;
            val_q    <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            rst_ac_q <= 1'b0;
            busy_q   <= 1'b1;
            en_ac_q  <= !ic_hold;
            val_q    <= !ic_hold;
            // Continuous wrap back to p_start leaves the accumulator running.
            if (dwell_end) begin
              p_q <= step_ok ? p_next[M-1:0] : p_start_q;
            end
          end
        end
        DONE: begin
          state_q  <= IDLE;
          rst_ac_q <= 1'b1;
          en_ac_q  <= 1'b0;
          val_q    <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign od_p_ac     = p_q;
  assign oc_rst_ac   = rst_ac_q;
  assign oc_en_ac    = en_ac_q;
  assign oc_val_data = val_q;
  assign oc_busy     = busy_q;
  assign oc_done     = done_q;

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that sits directly upstream of the DDS core (dds_mod_dds). It drives the core's phase step, accumulator reset, enable and data-valid inputs. It steps the phase increment P from a start value to a stop value in fixed increments and holds each value for a programmable number of valid samples, in one-shot or continuous mode. This turns the fixed-tone DDS into a stepped chirp source for the signal-processing chain.

Parameters:
M, 16, phase accumulator width; must match the DDS core's M.
DW_W, 16, width of the dwell-count input.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
ic_start  in  1  single-cycle request to start a sweep; honoured only in IDLE.
ic_abort  in  1  terminates an active sweep.
ic_hold  in  1  freezes the sweep and suppresses valid output while high.
ic_mode  in  1  0 = one-shot, 1 = continuous repeat.
id_p_start  in  M  first phase step (unsigned).
id_p_stop  in  M  last permitted phase step (unsigned).
id_p_step  in  M  increment added to P between dwells (unsigned).
id_dwell  in  DW_W  valid samples per P value; 0 is treated as 1.
od_p_ac  out  M  phase step to the DDS (drives id_p_ac).
oc_rst_ac  out  1  accumulator clear to the DDS (drives ic_rst_ac).
oc_en_ac  out  1  accumulator enable to the DDS (drives ic_en_ac).
oc_val_data  out  1  input-valid to the DDS (drives ic_val_data).
oc_busy  out  1  high in LOAD and RUN.
oc_done  out  1  one-cycle pulse at sweep end or abort.

Behaviour:
- All outputs are registered.
- Reset values: od_p_ac = 0, oc_rst_ac = 1, oc_en_ac = 0, oc_val_data = 0, oc_busy = 0, oc_done = 0. FSM goes to IDLE.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs hold their reset values, except od_p_ac keeps its last value.
  - On ic_start, capture p_start, p_stop, p_step, dwell and mode into shadow registers and go to LOAD.
- LOAD (exactly 1 cycle):
  - od_p_ac <= p_start, oc_rst_ac = 1, oc_busy = 1, val = en = 0.
  - Dwell counter loads max(dwell,1) - 1.
  - Next state is RUN.
  - Latency: ic_start sampled at edge k gives LOAD outputs after k+1; the first oc_val_data is high after edge k+2.
- RUN:
  - oc_rst_ac = 0, oc_busy = 1.
  - If ic_hold = 0: oc_en_ac = oc_val_data = 1 and the dwell counter decrements.
  - If ic_hold = 1: oc_en_ac = oc_val_data = 0 and all counters and P are frozen. Hold is a registered response, one cycle late.
- End of a dwell (counter = 0 on an unheld cycle):
  - Compute next = P + p_step in M+1 bits.
  - If p_step != 0 and next <= p_stop: P <= next[M-1:0] and the counter reloads.
  - Otherwise, in mode 1: P <= p_start and the counter reloads. No accumulator reset, so phase stays continuous.
  - Otherwise, in mode 0: go to DONE.
- P never wraps. Overflow beyond 2^M - 1 counts as exceeding p_stop.
- Degenerate configurations:
  - p_stop < p_start or p_step = 0: exactly one dwell at p_start (mode 0), or that dwell repeated forever (mode 1).
- One-shot sample count: N = (floor((p_stop - p_start) / p_step) + 1) * max(dwell,1), with no gaps unless held.
- ic_abort in LOAD or RUN: go to DONE at the next edge. It has priority over hold and dwell-end. Ignored in IDLE and DONE.
- DONE (1 cycle): oc_done = 1, oc_busy = 0, val = en = 0, oc_rst_ac = 1. Next state is IDLE.
- ic_start is ignored outside IDLE, including in DONE. Input changes outside IDLE have no effect because the shadow registers are used.
- rst_n asserted mid-sweep immediately forces the reset values. No oc_done is issued.

Decomposition:
- Shared package dds_pkg:
  - typedef enum logic [1:0] sweep_state_t {IDLE, LOAD, RUN, DONE}.
  - Default M and DW_W constants, reused by the DDS core and the bench.
- One sub-module, dds_dwell_cnt:
  - Loadable down-counter with enable, load and zero flag.
  - Width DW_W, asynchronous active-low reset.
- Step/compare arithmetic and the FSM stay in the top module.

Test Plan:
1. One-shot sweep (M=16, start=100, stop=400, step=100, dwell=3, mode 0) -> od_p_ac sequence 100,100,100,200×3,300×3,400×3. That is 12 contiguous valid cycles, starting 2 cycles after ic_start. oc_done pulses once, 1 cycle after the last valid, and oc_rst_ac is high only in LOAD and DONE.
2. Overflow guard (start=65000, stop=65535, step=400, dwell=1) -> P takes 65000 then 65400 (2 valid cycles) and is never wrapped to 264. Then oc_done.
3. Continuous mode (start=10, stop=30, step=10, dwell=2, mode 1) -> P repeats 10,10,20,20,30,30,10,... with oc_rst_ac never re-asserted. ic_abort mid-dwell gives DONE on the next edge and oc_done = 1.
4. Hold (scenario 1 config, ic_hold high 4 cycles during P=200) -> val and en are low for those 4 cycles and the count of 200-valued valid samples is still 3. Total valid is still 12.
5. Degenerate inputs: dwell=0 gives 1 sample per P. p_step=0 or stop<start gives exactly max(dwell,1) valid samples at p_start, then done. ic_start asserted during RUN is ignored.
6. Integration: rst_n pulsed low mid-RUN gives all outputs at reset values asynchronously and no oc_done. Chain with dds_mod_dds and check each dwell's sine against a golden file sample-by-sample, with zero errors.
